exe_stage: RTL and testbench

- Execute stage of the 5-stage MIPS32 pipeline; consumes the ID/EXE pipeline register outputs and feeds the EXE/MEM register.
- Computes ALU results, HI/LO moves with forwarding, and single-cycle MULT/MULTU.
- Runs DIV/DIVU on an iterative radix-2 divider that stalls the pipeline through stallreq.

---
 rtl/mips_defs_pkg.sv | 46 ++++
 rtl/div_iter.sv | 131 +++++++++++++
 rtl/exe_stage.sv | 150 +++++++++++++++
 tb/tb_exe_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS32 pipeline definitions: ALU type/op encodings and divider state encoding.
package mips_defs_pkg;

  localparam logic [2:0] ALUTYPE_NOP   = 3'd0;
  localparam logic [2:0] ALUTYPE_ARITH = 3'd1;
  localparam logic [2:0] ALUTYPE_LOGIC = 3'd2;
  localparam logic [2:0] ALUTYPE_MOVE  = 3'd3;
  localparam logic [2:0] ALUTYPE_SHIFT = 3'd4;
  localparam logic [2:0] ALUTYPE_JUMP  = 3'd5;

  localparam logic [7:0] ALUOP_NOP   = 8'h00;
  localparam logic [7:0] ALUOP_ADD   = 8'h01;
  localparam logic [7:0] ALUOP_ADDIU = 8'h02;
  localparam logic [7:0] ALUOP_ADDU  = 8'h03;
  localparam logic [7:0] ALUOP_SUBU  = 8'h04;
  localparam logic [7:0] ALUOP_SLT   = 8'h05;
  localparam logic [7:0] ALUOP_SLTU  = 8'h06;
  localparam logic [7:0] ALUOP_AND   = 8'h10;
  localparam logic [7:0] ALUOP_OR    = 8'h11;
  localparam logic [7:0] ALUOP_XOR   = 8'h12;
  localparam logic [7:0] ALUOP_NOR   = 8'h13;
  localparam logic [7:0] ALUOP_LUI   = 8'h14;
  localparam logic [7:0] ALUOP_SLL   = 8'h20;
  localparam logic [7:0] ALUOP_SRL   = 8'h21;
  localparam logic [7:0] ALUOP_SRA   = 8'h22;
  localparam logic [7:0] ALUOP_MFHI  = 8'h30;
  localparam logic [7:0] ALUOP_MFLO  = 8'h31;
  localparam logic [7:0] ALUOP_MTHI  = 8'h32;
  localparam logic [7:0] ALUOP_MTLO  = 8'h33;
  localparam logic [7:0] ALUOP_MULT  = 8'h40;
  localparam logic [7:0] ALUOP_MULTU = 8'h41;
  localparam logic [7:0] ALUOP_DIV   = 8'h42;
  localparam logic [7:0] ALUOP_DIVU  = 8'h43;
  localparam logic [7:0] ALUOP_JAL   = 8'h50;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div(input logic [7:0] op);
    return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed fix-up on the way out.
module div_iter
  import mips_defs_pkg::*;
#(
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  r_state;
  div_state_e  w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_divisor;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_zero;
  logic [31:0] w_abs_dvd;
  logic [31:0] w_abs_dvs;
  logic [32:0] w_shift;
  logic [32:0] w_diff;

  assign w_abs_dvd = (signed_op && dividend[31]) ? (32'd0 - dividend) : dividend;
  assign w_abs_dvs = (signed_op && divisor[31])  ? (32'd0 - divisor)  : divisor;
  assign w_shift   = {r_rem, r_quot[31]};
  assign w_diff    = w_shift - {1'b0, r_divisor};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and stall/done decode; reset and flush both drop the stall at once
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    if (flush || !rst_n) begin
      w_next = DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            busy   = 1'b1;
            w_next = (divisor == 32'd0) ? DIV_DONE : DIV_BUSY;
          end else begin
            w_next = DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          busy   = 1'b1;
          w_next = (r_cnt == 5'd31) ? DIV_DONE : DIV_BUSY;
        end
        DIV_DONE: begin
          done   = 1'b1;
          w_next = DIV_IDLE;
        end
        default: w_next = DIV_IDLE;
      endcase
    end
  end

  // Operand capture and shift-subtract datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 5'd0;
      r_divisor <= 32'd0;
      r_rem     <= 32'd0;
      r_quot    <= 32'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_zero    <= 1'b0;
    end else if (flush) begin
      r_cnt <= 5'd0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            r_cnt   <= 5'd0;
            r_neg_q <= signed_op & (dividend[31] ^ divisor[31]);
            r_neg_r <= signed_op & dividend[31];
            if (divisor == 32'd0) begin
              // Divide by zero: HI returns the raw dividend, no fix-up applied
              r_zero    <= 1'b1;
              r_rem     <= dividend;
              r_quot    <= DIV_ZERO_LO;
              r_divisor <= 32'd0;
            end else begin
              r_zero    <= 1'b0;
              r_rem     <= 32'd0;
              r_quot    <= w_abs_dvd;
              r_divisor <= w_abs_dvs;
            end
          end
        end
        DIV_BUSY: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_shift >= {1'b0, r_divisor}) begin
            r_rem  <= w_diff[31:0];
            r_quot <= {r_quot[30:0], 1'b1};
          end else begin
            r_rem  <= w_shift[31:0];
            r_quot <= {r_quot[30:0], 1'b0};
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign quotient  = (!r_zero && r_neg_q) ? (32'd0 - r_quot) : r_quot;
  assign remainder = (!r_zero && r_neg_r) ? (32'd0 - r_rem)  : r_rem;

endmodule

// File: rtl/exe_stage.sv
// MIPS32 execute stage: ALU, HI/LO forwarding, single-cycle multiply and the stalling divider.
module exe_stage
  import mips_defs_pkg::*;
#(
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [2:0]  exe_alutype_i,
  input  logic [7:0]  exe_aluop_i,
  input  logic [31:0] exe_src1_i,
  input  logic [31:0] exe_src2_i,
  input  logic [4:0]  exe_wa_i,
  input  logic        exe_wreg_i,
  input  logic        exe_mreg_i,
  input  logic [31:0] exe_din_i,
  input  logic        exe_whilo_i,
  input  logic [31:0] exe_ret_addr_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        mem_whilo_i,
  input  logic [63:0] mem_hilo_i,
  input  logic        wb_whilo_i,
  input  logic [63:0] wb_hilo_i,
  output logic [7:0]  exe_aluop_o,
  output logic [4:0]  exe_wa_o,
  output logic        exe_wreg_o,
  output logic        exe_mreg_o,
  output logic [31:0] exe_din_o,
  output logic [31:0] exe_wd_o,
  output logic        exe_whilo_o,
  output logic [63:0] exe_hilo_o,
  output logic        stallreq
);

  logic [31:0] w_fwd_hi;
  logic [31:0] w_fwd_lo;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_busy;
  logic        w_div_done;
  logic [31:0] w_div_q;
  logic [31:0] w_div_r;

  assign exe_aluop_o = exe_aluop_i;
  assign exe_wa_o    = exe_wa_i;
  assign exe_wreg_o  = exe_wreg_i;
  assign exe_mreg_o  = exe_mreg_i;
  assign exe_din_o   = exe_din_i;

  // Youngest HI/LO writer wins: MEM, then WB, then the architectural registers
  assign w_fwd_hi = mem_whilo_i ? mem_hilo_i[63:32] : (wb_whilo_i ? wb_hilo_i[63:32] : hi_i);
  assign w_fwd_lo = mem_whilo_i ? mem_hilo_i[31:0]  : (wb_whilo_i ? wb_hilo_i[31:0]  : lo_i);

  assign w_prod_s = {{32{exe_src1_i[31]}}, exe_src1_i} * {{32{exe_src2_i[31]}}, exe_src2_i};
  assign w_prod_u = {32'd0, exe_src1_i} * {32'd0, exe_src2_i};

  div_iter #(.DIV_ZERO_LO(DIV_ZERO_LO)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (is_div(exe_aluop_i)),
    .signed_op (exe_aluop_i == ALUOP_DIV),
    .dividend  (exe_src1_i),
    .divisor   (exe_src2_i),
    .flush     (flush),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_div_q),
    .remainder (w_div_r)
  );

  assign stallreq = w_div_busy;

  // Register-file result by ALU type
  always_comb begin
    exe_wd_o = 32'd0;
    case (exe_alutype_i)
      ALUTYPE_ARITH: begin
        case (exe_aluop_i)
          ALUOP_ADD, ALUOP_ADDIU, ALUOP_ADDU: exe_wd_o = exe_src1_i + exe_src2_i;
          ALUOP_SUBU: exe_wd_o = exe_src1_i - exe_src2_i;
          ALUOP_SLT:  exe_wd_o = ($signed(exe_src1_i) < $signed(exe_src2_i)) ? 32'd1 : 32'd0;
          ALUOP_SLTU: exe_wd_o = (exe_src1_i < exe_src2_i) ? 32'd1 : 32'd0;
          default:    exe_wd_o = 32'd0;
        endcase
      end
      ALUTYPE_LOGIC: begin
        case (exe_aluop_i)
          ALUOP_AND: exe_wd_o = exe_src1_i & exe_src2_i;
          ALUOP_OR:  exe_wd_o = exe_src1_i | exe_src2_i;
          ALUOP_XOR: exe_wd_o = exe_src1_i ^ exe_src2_i;
          ALUOP_NOR: exe_wd_o = ~(exe_src1_i | exe_src2_i);
          ALUOP_LUI: exe_wd_o = {exe_src2_i[15:0], 16'h0000};
          default:   exe_wd_o = 32'd0;
        endcase
      end
      ALUTYPE_MOVE: begin
        case (exe_aluop_i)
          ALUOP_MFHI: exe_wd_o = w_fwd_hi;
          ALUOP_MFLO: exe_wd_o = w_fwd_lo;
          default:    exe_wd_o = 32'd0;
        endcase
      end
      ALUTYPE_SHIFT: begin
        case (exe_aluop_i)
          ALUOP_SLL: exe_wd_o = exe_src2_i << exe_src1_i[4:0];
          ALUOP_SRL: exe_wd_o = exe_src2_i >> exe_src1_i[4:0];
          ALUOP_SRA: exe_wd_o = $unsigned($signed(exe_src2_i) >>> exe_src1_i[4:0]);
          default:   exe_wd_o = 32'd0;
        endcase
      end
      ALUTYPE_JUMP: exe_wd_o = exe_ret_addr_i;
      default:      exe_wd_o = 32'd0;
    endcase
  end

  // HI/LO write request and data
  always_comb begin
    exe_whilo_o = exe_whilo_i;
    exe_hilo_o  = 64'd0;
    case (exe_aluop_i)
      ALUOP_MULT: begin
        exe_whilo_o = 1'b1;
        exe_hilo_o  = w_prod_s;
      end
      ALUOP_MULTU: begin
        exe_whilo_o = 1'b1;
        exe_hilo_o  = w_prod_u;
      end
      ALUOP_MTHI: begin
        exe_whilo_o = 1'b1;
        exe_hilo_o  = {exe_src1_i, w_fwd_lo};
      end
      ALUOP_MTLO: begin
        exe_whilo_o = 1'b1;
        exe_hilo_o  = {w_fwd_hi, exe_src1_i};
      end
      ALUOP_DIV, ALUOP_DIVU: begin
        exe_whilo_o = w_div_done;
        exe_hilo_o  = {w_div_r, w_div_q};
      end
      default: begin
        exe_whilo_o = exe_whilo_i;
        exe_hilo_o  = 64'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage: ALU, forwarding, multiply, divider timing, flush and reset.
module tb_exe_stage;
  import mips_defs_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [2:0]  exe_alutype_i;
  logic [7:0]  exe_aluop_i;
  logic [31:0] exe_src1_i;
  logic [31:0] exe_src2_i;
  logic [4:0]  exe_wa_i;
  logic        exe_wreg_i;
  logic        exe_mreg_i;
  logic [31:0] exe_din_i;
  logic        exe_whilo_i;
  logic [31:0] exe_ret_addr_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        mem_whilo_i;
  logic [63:0] mem_hilo_i;
  logic        wb_whilo_i;
  logic [63:0] wb_hilo_i;
  logic [7:0]  exe_aluop_o;
  logic [4:0]  exe_wa_o;
  logic        exe_wreg_o;
  logic        exe_mreg_o;
  logic [31:0] exe_din_o;
  logic [31:0] exe_wd_o;
  logic        exe_whilo_o;
  logic [63:0] exe_hilo_o;
  logic        stallreq;

  int n_vec;
  int n_err;

  exe_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .exe_alutype_i  (exe_alutype_i),
    .exe_aluop_i    (exe_aluop_i),
    .exe_src1_i     (exe_src1_i),
    .exe_src2_i     (exe_src2_i),
    .exe_wa_i       (exe_wa_i),
    .exe_wreg_i     (exe_wreg_i),
    .exe_mreg_i     (exe_mreg_i),
    .exe_din_i      (exe_din_i),
    .exe_whilo_i    (exe_whilo_i),
    .exe_ret_addr_i (exe_ret_addr_i),
    .hi_i           (hi_i),
    .lo_i           (lo_i),
    .mem_whilo_i    (mem_whilo_i),
    .mem_hilo_i     (mem_hilo_i),
    .wb_whilo_i     (wb_whilo_i),
    .wb_hilo_i      (wb_hilo_i),
    .exe_aluop_o    (exe_aluop_o),
    .exe_wa_o       (exe_wa_o),
    .exe_wreg_o     (exe_wreg_o),
    .exe_mreg_o     (exe_mreg_o),
    .exe_din_o      (exe_din_o),
    .exe_wd_o       (exe_wd_o),
    .exe_whilo_o    (exe_whilo_o),
    .exe_hilo_o     (exe_hilo_o),
    .stallreq       (stallreq)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] t, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    exe_alutype_i = t;
    exe_aluop_i   = op;
    exe_src1_i    = a;
    exe_src2_i    = b;
    #1;
  endtask

  // Issue a divide held in EXE while stalled; count stall cycles and check the result cycle
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cyc, input logic [63:0] exp_hilo);
    int cyc;
    logic early_whilo;
    cyc = 0;
    early_whilo = 1'b0;
    drive(ALUTYPE_ARITH, op, a, b);
    while (stallreq && cyc < 100) begin
      if (exe_whilo_o) early_whilo = 1'b1;
      cyc = cyc + 1;
      @(posedge clk);
      #2;
    end
    chk({tag, "_stall_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_whilo_during_stall"}, 64'(early_whilo), 64'd0);
    chk({tag, "_whilo_done"}, 64'(exe_whilo_o), 64'd1);
    chk({tag, "_hilo"}, exe_hilo_o, exp_hilo);
    @(posedge clk);
    #1;
    drive(ALUTYPE_NOP, ALUOP_NOP, 32'd0, 32'd0);
    chk({tag, "_whilo_after"}, 64'(exe_whilo_o), 64'd0);
    chk({tag, "_stall_after"}, 64'(stallreq), 64'd0);
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    flush          = 1'b0;
    exe_wa_i       = 5'd17;
    exe_wreg_i     = 1'b1;
    exe_mreg_i     = 1'b0;
    exe_din_i      = 32'hCAFE_F00D;
    exe_whilo_i    = 1'b0;
    exe_ret_addr_i = 32'h0040_0108;
    hi_i           = 32'hAAAA_0000;
    lo_i           = 32'h0000_BBBB;
    mem_whilo_i    = 1'b0;
    mem_hilo_i     = 64'd0;
    wb_whilo_i     = 1'b0;
    wb_hilo_i      = 64'd0;

    // Reset with a divide present: no stall, no HI/LO write
    drive(ALUTYPE_ARITH, ALUOP_DIV, 32'd9, 32'd3);
    chk("reset_stall", 64'(stallreq), 64'd0);
    chk("reset_whilo", 64'(exe_whilo_o), 64'd0);
    drive(ALUTYPE_NOP, ALUOP_NOP, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    chk("passthrough", {27'd0, exe_aluop_o, exe_wa_o, exe_wreg_o, exe_mreg_o, exe_din_o},
        {27'd0, 8'h00, 5'd17, 1'b1, 1'b0, 32'hCAFE_F00D});
    chk("nop_wd", 64'(exe_wd_o), 64'd0);

    drive(ALUTYPE_ARITH, ALUOP_ADDU, 32'h7FFF_FFFF, 32'd1);
    chk("addu_wrap", 64'(exe_wd_o), 64'h8000_0000);
    drive(ALUTYPE_ARITH, ALUOP_SUBU, 32'd3, 32'd5);
    chk("subu", 64'(exe_wd_o), 64'hFFFF_FFFE);
    drive(ALUTYPE_ARITH, ALUOP_SLT, 32'hFFFF_FFFF, 32'd1);
    chk("slt", 64'(exe_wd_o), 64'd1);
    drive(ALUTYPE_ARITH, ALUOP_SLTU, 32'hFFFF_FFFF, 32'd1);
    chk("sltu", 64'(exe_wd_o), 64'd0);
    drive(ALUTYPE_LOGIC, ALUOP_NOR, 32'hF0F0_0000, 32'h0000_00FF);
    chk("nor", 64'(exe_wd_o), 64'h0F0F_FF00);
    drive(ALUTYPE_LOGIC, ALUOP_LUI, 32'd0, 32'h0000_1234);
    chk("lui", 64'(exe_wd_o), 64'h1234_0000);
    drive(ALUTYPE_SHIFT, ALUOP_SRA, 32'd4, 32'h8000_0000);
    chk("sra", 64'(exe_wd_o), 64'hF800_0000);
    drive(ALUTYPE_SHIFT, ALUOP_SRL, 32'd36, 32'h8000_0000);
    chk("srl_amt_low5", 64'(exe_wd_o), 64'h0800_0000);
    drive(ALUTYPE_JUMP, ALUOP_JAL, 32'd1, 32'd2);
    chk("jump", 64'(exe_wd_o), 64'h0040_0108);

    // HI/LO forwarding priority
    mem_whilo_i = 1'b1;
    mem_hilo_i  = 64'h1111_1111_2222_2222;
    wb_whilo_i  = 1'b1;
    wb_hilo_i   = 64'h3333_3333_4444_4444;
    drive(ALUTYPE_MOVE, ALUOP_MFHI, 32'd0, 32'd0);
    chk("mfhi_mem", 64'(exe_wd_o), 64'h1111_1111);
    mem_whilo_i = 1'b0;
    drive(ALUTYPE_MOVE, ALUOP_MFHI, 32'd0, 32'd0);
    chk("mfhi_wb", 64'(exe_wd_o), 64'h3333_3333);
    drive(ALUTYPE_MOVE, ALUOP_MTHI, 32'h5555_5555, 32'd0);
    chk("mthi", exe_hilo_o, 64'h5555_5555_4444_4444);
    wb_whilo_i = 1'b0;
    drive(ALUTYPE_MOVE, ALUOP_MFLO, 32'd0, 32'd0);
    chk("mflo_arch", 64'(exe_wd_o), 64'h0000_BBBB);
    drive(ALUTYPE_MOVE, ALUOP_MTLO, 32'h6666_6666, 32'd0);
    chk("mtlo", {63'd0, exe_whilo_o, exe_hilo_o}, {63'd1, 64'hAAAA_0000_6666_6666});

    drive(ALUTYPE_ARITH, ALUOP_MULT, 32'hFFFF_FFFD, 32'd5);
    chk("mult", exe_hilo_o, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mult_whilo", 64'(exe_whilo_o), 64'd1);
    drive(ALUTYPE_ARITH, ALUOP_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("multu", exe_hilo_o, 64'h0000_0001_FFFF_FFFE);

    // Divides, back to back
    @(posedge clk);
    #1;
    run_div("div_m7_2", ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
    run_div("divu_100_7", ALUOP_DIVU, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    run_div("div_5_0", ALUOP_DIV, 32'd5, 32'd0, 1, {32'd5, 32'hFFFF_FFFF});
    run_div("div_min_m1", ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000});

    // Flush during the 10th busy cycle
    drive(ALUTYPE_ARITH, ALUOP_DIV, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    chk("flush_stall", 64'(stallreq), 64'd0);
    chk("flush_whilo", 64'(exe_whilo_o), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    drive(ALUTYPE_NOP, ALUOP_NOP, 32'd0, 32'd0);
    chk("post_flush_stall", 64'(stallreq), 64'd0);
    run_div("div_after_flush", ALUOP_DIVU, 32'd100, 32'd7, 33, {32'd2, 32'd14});

    // Asynchronous reset mid-divide
    drive(ALUTYPE_ARITH, ALUOP_DIV, 32'd50, 32'd3);
    repeat (5) @(posedge clk);
    #3;
    chk("pre_reset_stall", 64'(stallreq), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_stall", 64'(stallreq), 64'd0);
    chk("async_reset_whilo", 64'(exe_whilo_o), 64'd0);
    drive(ALUTYPE_NOP, ALUOP_NOP, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_div("div_after_reset", ALUOP_DIV, 32'd50, 32'hFFFF_FFFD, 33, {32'd2, 32'hFFFF_FFF0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
